// File: rtl/ckpt_mon_pkg.sv
// Shared types and width helpers for the checkpoint monitor.
package ckpt_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } ckpt_state_e;

    // Width of the step index, which must also be able to hold NUM_STEPS.
    function automatic int step_w(input int num_steps);
        return ($clog2(num_steps + 1) > 0) ? $clog2(num_steps + 1) : 1;
    endfunction

    // Width of the per-step cycle counter, which saturates at TIMEOUT_CYCLES.
    function automatic int cyc_w(input int timeout_cycles);
        return ($clog2(timeout_cycles + 1) > 0) ? $clog2(timeout_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/ckpt_step_timer.sv
// Per-step watchdog: saturating up-counter with clear/enable.
// o_expire is raised while the count sits at TIMEOUT_CYCLES-1.
module ckpt_step_timer #(
    parameter int TIMEOUT_CYCLES = 250000,
    parameter int CNT_W          = 18
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_expire
);

    localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] EXP_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Count enabled cycles; clear wins over enable; never wrap.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != SAT_VAL)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_expire = (r_count == EXP_VAL);

endmodule

// File: rtl/gpio_checkpoint_monitor.sv
// Checkpoint sequencer on the checkbit bus: walks an ordered list of
// marker values, runs a per-step watchdog and reports pass/fail/timeout.
// Optional macro CKPT_STABLE_EN: a match (and the fail marker) must hold
// unchanged on the sampled bus for STABLE_CYCLES consecutive cycles.
module gpio_checkpoint_monitor
    import ckpt_mon_pkg::*;
#(
    parameter int  CHECK_W        = 16,
    parameter int  NUM_STEPS      = 2,
    parameter int  TIMEOUT_CYCLES = 250000,
    parameter int  STABLE_CYCLES  = 4,
    localparam int STEP_W         = step_w(NUM_STEPS),
    localparam int CYC_W          = cyc_w(TIMEOUT_CYCLES)
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           arm_i,
    input  logic [CHECK_W-1:0]             checkbits_i,
    input  logic [NUM_STEPS*CHECK_W-1:0]   exp_vals_i,
    input  logic [CHECK_W-1:0]             fail_val_i,
    input  logic                           fail_en_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           pass_o,
    output logic                           fail_o,
    output logic                           timeout_o,
    output logic [STEP_W-1:0]              step_o,
    output logic [CHECK_W-1:0]             last_val_o,
    output logic [CYC_W-1:0]               cycles_o
);

    ckpt_state_e        r_state, w_state_next;
    logic [STEP_W-1:0]  r_step, w_step_next;
    logic [CHECK_W-1:0] r_last_val, w_last_next;
    logic               r_first, w_first_next;
    logic [CHECK_W-1:0] r_cb_q, r_cb_qq;
    logic [CHECK_W-1:0] w_exp;
    logic               w_stable, w_fresh, w_match, w_fail;
    logic               w_tmr_clr, w_tmr_en, w_expire;
    logic               w_unused_cfg;

    // Expected-marker table padded to a power of two so any step index is legal.
    logic [CHECK_W-1:0] w_exp_tbl [2**STEP_W];
    for (genvar gi = 0; gi < 2**STEP_W; gi++) begin : g_exp
        if (gi < NUM_STEPS) begin : g_used
            assign w_exp_tbl[gi] = exp_vals_i[gi*CHECK_W +: CHECK_W];
        end else begin : g_pad
            assign w_exp_tbl[gi] = '0;
        end
    end
    assign w_exp = w_exp_tbl[r_step];

    // Two-deep sampling of the checkbit bus.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cb_q  <= '0;
            r_cb_qq <= '0;
        end else begin
            r_cb_q  <= checkbits_i;
            r_cb_qq <= r_cb_q;
        end
    end

`ifdef CKPT_STABLE_EN
    localparam int               STB_W     = $clog2(STABLE_CYCLES + 2);
    localparam logic [STB_W-1:0] STB_MATCH = STB_W'(STABLE_CYCLES);
    localparam logic [STB_W-1:0] STB_SAT   = STB_W'(STABLE_CYCLES + 1);
    logic [STB_W-1:0] r_run_len;

    // Length of the current run of identical values in r_cb_q.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_run_len <= '0;
        end else if (checkbits_i != r_cb_q) begin
            r_run_len <= STB_W'(1);
        end else if (r_run_len != STB_SAT) begin
            r_run_len <= r_run_len + 1'b1;
        end
    end

    // A match fires once, on the cycle the run first becomes long enough.
    assign w_stable = (r_run_len >= STB_MATCH);
    assign w_fresh  = (r_run_len == STB_MATCH) || (r_first && w_stable);
`else
    assign w_stable = 1'b1;
    assign w_fresh  = (r_cb_q != r_cb_qq) || r_first;
`endif
    assign w_unused_cfg = (STABLE_CYCLES > 0);

    assign w_match = (r_cb_q == w_exp) && w_fresh;
    assign w_fail  = fail_en_i && (r_cb_q == fail_val_i) && w_stable;

    ckpt_step_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CYC_W)
    ) u_timer (
        .clk      (wb_clk_i),
        .srst     (wb_rst_i),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_count  (cycles_o),
        .o_expire (w_expire)
    );

    // State, step and terminal-value registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_step     <= '0;
            r_last_val <= '0;
            r_first    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_step     <= w_step_next;
            r_last_val <= w_last_next;
            r_first    <= w_first_next;
        end
    end

    // Sequencing: fail beats match beats timeout; arm only acts outside RUN.
    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        w_last_next  = r_last_val;
        w_first_next = 1'b0;
        w_tmr_clr    = 1'b0;
        w_tmr_en     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_fail) begin
                    w_state_next = ST_FAIL;
                    w_last_next  = r_cb_q;
                end else if (w_match) begin
                    if (r_step == STEP_W'(NUM_STEPS - 1)) begin
                        w_state_next = ST_PASS;
                        w_step_next  = STEP_W'(NUM_STEPS);
                        w_last_next  = r_cb_q;
                    end else begin
                        w_step_next  = r_step + 1'b1;
                        w_tmr_clr    = 1'b1;
                    end
                end else if (w_expire) begin
                    w_state_next = ST_TIMEOUT;
                    w_last_next  = r_cb_q;
                end else begin
                    w_tmr_en     = 1'b1;
                end
            end
            default: begin
                if (arm_i) begin
                    w_state_next = ST_RUN;
                    w_step_next  = '0;
                    w_first_next = 1'b1;
                    w_tmr_clr    = 1'b1;
                end
            end
        endcase
    end

    assign busy_o     = (r_state == ST_RUN);
    assign pass_o     = (r_state == ST_PASS);
    assign fail_o     = (r_state == ST_FAIL);
    assign timeout_o  = (r_state == ST_TIMEOUT);
    assign done_o     = pass_o || fail_o || timeout_o;
    assign step_o     = r_step;
    assign last_val_o = r_last_val;

endmodule
